// File: rtl/j1b_stack_pkg.sv
// Shared encodings for the J1B stack-control path and the stack guard FSM.
package j1b_stack_pkg;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_ILL  = 2'b10;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_UNF  = 2'b10;
    localparam logic [1:0] CAUSE_ILL  = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } guard_state_t;

endpackage

// File: rtl/stack_guard_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment loads 1 so the event that caused it is not lost.
module stack_guard_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? {{(W-1){1'b0}}, 1'b1} : '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stack_guard.sv
// Guard between the J1B stack controls and a stack2 instance: squashes
// overflow/underflow/illegal deltas and traps. Optional hwm via STACK_GUARD_HWM_EN.
//
// state | meaning
// RUN   | controls pass through; violations are detected
// TRAP  | controls frozen; waiting for trap_ack
module stack_guard
    import j1b_stack_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PW    = 5,
    parameter int ECW   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     delta_i,
    input  logic           we_i,
    output logic [1:0]     delta_o,
    output logic           we_o,
    input  logic [PW-1:0]  depth,
    output logic           trap_req,
    input  logic           trap_ack,
    output logic [1:0]     trap_cause,
    output logic [2:0]     sticky,
    output logic [ECW-1:0] err_count,
    input  logic           clr,
    output logic [PW-1:0]  hwm
);

    guard_state_t state, state_nxt;
    logic         ovf, unf, ill, viol;
    logic [1:0]   cause_now;
    logic [2:0]   viol_bits;
    logic [1:0]   cause_q;
    logic [2:0]   sticky_q;

    always_comb begin
        ill       = (delta_i == DELTA_ILL);
        ovf       = (delta_i == DELTA_PUSH) && (depth == PW'(DEPTH - 1));
        unf       = (delta_i == DELTA_POP) && (depth == '0);
        viol      = (state == RUN) && (ill || ovf || unf);
        cause_now = ill ? CAUSE_ILL : (ovf ? CAUSE_OVF : (unf ? CAUSE_UNF : CAUSE_NONE));
        viol_bits = viol ? {ill, unf && !ovf, ovf && !ill} : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        delta_o   = DELTA_HOLD;
        we_o      = 1'b0;
        case (state)
            RUN: begin
                if (viol) begin
                    state_nxt = TRAP;
                end else begin
                    delta_o = delta_i;
                    we_o    = we_i;
                end
            end
            TRAP: begin
                if (trap_ack) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q  <= CAUSE_NONE;
            sticky_q <= 3'b000;
        end else begin
            if (viol) begin
                cause_q <= cause_now;
            end else if ((state == TRAP) && trap_ack) begin
                cause_q <= CAUSE_NONE;
            end
            sticky_q <= clr ? viol_bits : (sticky_q | viol_bits);
        end
    end

    stack_guard_cnt #(.W(ECW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (viol),
        .count (err_count)
    );

`ifdef STACK_GUARD_HWM_EN
    logic [PW-1:0] hwm_q;

    // Sampled depth lands one cycle later; a clear restarts tracking from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm_q <= '0;
        end else if (clr) begin
            hwm_q <= '0;
        end else if (depth > hwm_q) begin
            hwm_q <= depth;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

    assign trap_req   = (state == TRAP);
    assign trap_cause = cause_q;
    assign sticky     = sticky_q;

endmodule

// File: tb/tb_stack_guard.sv
// Self-checking bench for stack_guard: vector table, directed corner cases and
// randomized traffic against a behavioural model of the guard and the stack pointer.
module tb_stack_guard;
    import j1b_stack_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] delta_i = 2'b00;
    logic       we_i = 1'b0;
    logic [1:0] delta_o;
    logic       we_o;
    logic [4:0] depth = 5'd0;
    logic       trap_req;
    logic       trap_ack = 1'b0;
    logic [1:0] trap_cause;
    logic [2:0] sticky;
    logic [7:0] err_count;
    logic       clr = 1'b0;
    logic [4:0] hwm;

    stack_guard dut (
        .clk        (clk),
        .reset      (reset),
        .delta_i    (delta_i),
        .we_i       (we_i),
        .delta_o    (delta_o),
        .we_o       (we_o),
        .depth      (depth),
        .trap_req   (trap_req),
        .trap_ack   (trap_ack),
        .trap_cause (trap_cause),
        .sticky     (sticky),
        .err_count  (err_count),
        .clr        (clr),
        .hwm        (hwm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // stack pointer of the emulated stack2, moved by the DUT's actual outputs
    logic [4:0] env_depth = 5'd0;

    // behavioural model of the guard
    bit         m_trap;
    int         m_cause;
    int         m_sticky;
    int         m_cnt;
    int         m_hwm;

    logic [1:0] cur_d;
    logic       cur_w, cur_a, cur_c;

    typedef struct {
        logic [1:0] d;
        logic       w;
        logic       a;
        logic [1:0] x_delta;
        logic       x_we;
        logic       x_trap;
        logic [1:0] x_cause;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_viol();
        return !m_trap && (cur_d == 2'b10 || (cur_d == 2'b01 && env_depth == 5'd31) ||
                           (cur_d == 2'b11 && env_depth == 5'd0));
    endfunction

    task automatic apply(input logic [1:0] d, input logic w, input logic a, input logic c);
        cur_d = d; cur_w = w; cur_a = a; cur_c = c;
        delta_i = d; we_i = w; trap_ack = a; clr = c; depth = env_depth;
        #3;
    endtask

    task automatic model_check();
        bit squash;
        squash = m_trap || model_viol();
        chk("delta_o", delta_o, squash ? 2'b00 : cur_d);
        chk("we_o", we_o, squash ? 1'b0 : cur_w);
        chk("trap_req", trap_req, m_trap);
        chk("trap_cause", trap_cause, m_cause);
        chk("sticky", sticky, m_sticky);
        chk("err_count", err_count, m_cnt);
        chk("hwm", hwm, m_hwm);
    endtask

    task automatic advance();
        bit v;
        int c;
        v = model_viol();
        c = (cur_d == 2'b10) ? 3 : ((cur_d == 2'b01) ? 1 : 2);
        if (cur_c) begin
            m_sticky = 0;
            m_cnt = 0;
        end
`ifdef STACK_GUARD_HWM_EN
        m_hwm = cur_c ? 0 : ((int'(env_depth) > m_hwm) ? int'(env_depth) : m_hwm);
`endif
        if (v) begin
            m_sticky = m_sticky | (1 << (c - 1));
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_trap = 1'b1;
            m_cause = c;
        end else if (m_trap && cur_a) begin
            m_trap = 1'b0;
            m_cause = 0;
        end
        if (delta_o == 2'b01) env_depth = env_depth + 5'd1;
        else if (delta_o == 2'b11) env_depth = env_depth - 5'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] d, input logic w, input logic a, input logic c);
        apply(d, w, a, c);
        model_check();
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        delta_i = 2'b00; we_i = 1'b0; trap_ack = 1'b0; clr = 1'b0;
        env_depth = 5'd0; depth = 5'd0;
        m_trap = 1'b0; m_cause = 0; m_sticky = 0; m_cnt = 0; m_hwm = 0;
        #2;
        chk("rst trap_req", trap_req, 0);
        chk("rst trap_cause", trap_cause, 0);
        chk("rst sticky", sticky, 0);
        chk("rst err_count", err_count, 0);
        chk("rst hwm", hwm, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //           d      w     a     x_delta x_we  x_trap x_cause
        vecs[0]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
        vecs[5]  = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10};
        vecs[6]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b10};
        vecs[7]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[8]  = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b11};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].d, vecs[i].w, vecs[i].a, 1'b0);
            chk($sformatf("vec%0d delta_o", i), delta_o, vecs[i].x_delta);
            chk($sformatf("vec%0d we_o", i), we_o, vecs[i].x_we);
            chk($sformatf("vec%0d trap_req", i), trap_req, vecs[i].x_trap);
            chk($sformatf("vec%0d trap_cause", i), trap_cause, vecs[i].x_cause);
            model_check();
            advance();
        end
        chk("vec sticky", sticky, 3'b110);
        chk("vec err_count", err_count, 2);

        // overflow at the top of the stack
        do_reset();
        for (int i = 0; i < 31; i++) step(DELTA_PUSH, 1'b1, 1'b0, 1'b0);
        chk("push31 depth", env_depth, 31);
        chk("push31 trap_req", trap_req, 0);
        apply(DELTA_PUSH, 1'b1, 1'b0, 1'b0);
        chk("ovf delta_o", delta_o, 2'b00);
        chk("ovf we_o", we_o, 1'b0);
        model_check();
        advance();
        apply(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("ovf trap_req", trap_req, 1);
        chk("ovf cause", trap_cause, 2'b01);
        chk("ovf sticky", sticky, 3'b001);
        chk("ovf err_count", err_count, 1);
        chk("ovf depth", env_depth, 31);
        model_check();
        advance();

        // underflow, violation inside TRAP ignored, ack
        do_reset();
        apply(DELTA_POP, 1'b0, 1'b0, 1'b0);
        chk("unf delta_o", delta_o, 2'b00);
        advance();
        apply(DELTA_POP, 1'b0, 1'b0, 1'b0);
        chk("unf cause", trap_cause, 2'b10);
        chk("unf sticky", sticky, 3'b010);
        model_check();
        advance();
        apply(DELTA_HOLD, 1'b0, 1'b1, 1'b0);
        chk("unf err_count in trap", err_count, 1);
        model_check();
        advance();
        apply(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("ack trap_req", trap_req, 0);
        chk("ack sticky kept", sticky, 3'b010);
        model_check();
        advance();

        // illegal delta mid-stack
        do_reset();
        for (int i = 0; i < 5; i++) step(DELTA_PUSH, 1'b1, 1'b0, 1'b0);
        apply(DELTA_ILL, 1'b1, 1'b0, 1'b0);
        chk("ill delta_o", delta_o, 2'b00);
        chk("ill we_o", we_o, 1'b0);
        advance();
        apply(DELTA_HOLD, 1'b0, 1'b1, 1'b0);
        chk("ill cause", trap_cause, 2'b11);
        chk("ill depth", env_depth, 5);
        model_check();
        advance();

        // counter saturation, clear, clear colliding with a violation
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(DELTA_ILL, 1'b0, 1'b0, 1'b0);
            step(DELTA_HOLD, 1'b0, 1'b1, 1'b0);
        end
        chk("sat 255", err_count, 255);
        step(DELTA_ILL, 1'b0, 1'b0, 1'b0);
        step(DELTA_HOLD, 1'b0, 1'b1, 1'b0);
        apply(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("sat hold", err_count, 255);
        advance();
        step(DELTA_HOLD, 1'b0, 1'b0, 1'b1);
        apply(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("clr err_count", err_count, 0);
        chk("clr sticky", sticky, 0);
        advance();
        step(DELTA_POP, 1'b0, 1'b0, 1'b0);
        step(DELTA_HOLD, 1'b0, 1'b1, 1'b0);
        step(DELTA_ILL, 1'b0, 1'b0, 1'b1);
        apply(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("clr+viol err_count", err_count, 1);
        chk("clr+viol sticky", sticky, 3'b100);
        chk("clr keeps trap", trap_req, 1);
        model_check();
        advance();

        // asynchronous reset while trapped
        do_reset();
        step(DELTA_ILL, 1'b0, 1'b0, 1'b0);
        chk("pre-rst trap_req", trap_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async trap_req", trap_req, 0);
        chk("async sticky", sticky, 0);
        chk("async err_count", err_count, 0);
        do_reset();

`ifdef STACK_GUARD_HWM_EN
        for (int i = 0; i < 12; i++) step(DELTA_PUSH, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(DELTA_POP, 1'b0, 1'b0, 1'b0);
        step(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("hwm peak", hwm, 12);
        step(DELTA_HOLD, 1'b0, 1'b0, 1'b1);
        step(DELTA_HOLD, 1'b0, 1'b0, 1'b0);
        chk("hwm after clr", hwm, 3);
        do_reset();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] d;
            r = $urandom_range(0, 99);
            d = (r < 45) ? DELTA_PUSH : (r < 80) ? DELTA_POP : (r < 95) ? DELTA_HOLD : DELTA_ILL;
            step(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_guard.md
Name: stack_guard

Overview:
- Inline filter between the J1B core's stack-control outputs (delta, we, wd) and one stack2 instance (data or return stack).
- Monitors the stack depth against each requested delta and detects overflow, underflow and illegal delta before the stack pointer wraps.
- On a violation it squashes the operation, raises a trap request to the core and holds it until acknowledged.
- Keeps sticky status, a saturating error counter and an optional high-water mark for debug readout.

Parameters:
- DEPTH, 32, entries in the guarded stack; must match the stack2 DEPTH; power of two, max 32.
- PW, 5, pointer/depth width; equals log2(DEPTH).
- ECW, 8, width of the error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- delta_i  in  2  stack delta from core (01 push, 11 pop, 00 hold, 10 illegal).
- we_i  in  1  stack write enable from core.
- delta_o  out  2  delta to stack2.
- we_o  out  1  write enable to stack2.
- depth  in  PW  current pointer from stack2.
- trap_req  out  1  violation pending; level, held until acknowledged.
- trap_ack  in  1  core acknowledge, single-cycle pulse.
- trap_cause  out  2  00 none, 01 overflow, 10 underflow, 11 illegal delta.
- sticky  out  3  accumulated {illegal, underflow, overflow}.
- err_count  out  ECW  saturating count of violations.
- clr  in  1  synchronous clear of sticky, err_count and hwm.
- hwm  out  PW  maximum depth seen (only with the optional feature).

Behaviour:
- Reset values: all outputs 0; FSM in RUN; trap_cause 00.
- Violation is combinational on depth and delta_i, evaluated only in RUN:
  - ovf = (delta_i==01) and (depth==DEPTH-1).
  - unf = (delta_i==11) and (depth==0).
  - ill = (delta_i==10).
  - Priority: ill > ovf > unf.
- Passthrough, zero latency:
  - In RUN with no violation: delta_o=delta_i, we_o=we_i.
  - Otherwise (violation, or any cycle in TRAP): delta_o=00, we_o=0. The stack is frozen and never wraps.
- FSM:
  - RUN -> TRAP on a violation. In that cycle trap_cause is registered, the matching sticky bit is set and err_count increments; trap_req is 1 from the next cycle.
  - TRAP: trap_req=1; further violations are ignored, not counted and not recorded.
  - TRAP -> RUN on trap_ack. trap_req and trap_cause return to 0 the next cycle; sticky and err_count are kept.
  - trap_ack in RUN: ignored.
- err_count saturates at all-ones and does not wrap.
- clr:
  - Zeroes sticky, err_count and hwm the next cycle.
  - If a violation occurs in the same cycle, the violation wins for its own bit and the counter becomes 1.
  - clr does not affect the FSM or trap_req.
- Reset mid-trap: asynchronous return to RUN with all state cleared.
- Illegal delta 10 is always squashed, independent of depth.

Optional Feature:
- Macro STACK_GUARD_HWM_EN.
- Defined: hwm register updates each cycle to max(hwm, depth), cleared by reset and clr. Update is pipelined one cycle behind depth.
- Undefined: no hwm register; the hwm port still exists and is tied to 0.

Decomposition:
- Shared package j1b_stack_pkg holds:
  - delta encodings DELTA_HOLD=2'b00, DELTA_PUSH=2'b01, DELTA_ILL=2'b10, DELTA_POP=2'b11;
  - cause encodings CAUSE_NONE/OVF/UNF/ILL;
  - FSM state typedef {RUN, TRAP}.
- One sub-module, stack_guard_cnt: generic saturating counter with clear and increment, width ECW.

Test Plan:
- Push 31 times from depth 0 -> depth reaches 31, no trap. 32nd push -> delta_o=00, trap_req=1, trap_cause=01, sticky=001, err_count=1, depth stays 31.
- At depth 0, pop -> squashed, trap_cause=10, sticky=010. Pop again while in TRAP -> err_count stays 1. trap_ack -> trap_req=0 next cycle, sticky retained.
- delta_i=10 at depth 5 -> squashed, cause=11, depth stays 5.
- Force err_count to 255 via repeated trap/ack cycles -> next violation leaves it at 255. clr -> 0.
- Assert reset asynchronously while trap_req=1 -> trap_req, sticky and err_count are 0 immediately, without waiting for a clock edge.
- With STACK_GUARD_HWM_EN: push to 12, pop to 3 -> hwm=12; clr -> hwm=3 two cycles later. Without the macro -> hwm=0 throughout.
